// File: rtl/xoodyak_pkg.sv
// Shared constants, FSM encoding and byte helper for the Xoodyak hash controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xoodyak_pkg;

    localparam int STATE_BYTES = 48;
    localparam int STATE_W     = 384;

    localparam logic [7:0] PAD_BYTE   = 8'h01;
    localparam logic [7:0] CD_FIRST   = 8'h03;
    localparam logic [7:0] CU_SQUEEZE = 8'h40;

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        DOWN,
        SQ_UP,
        PERM_REQ,
        PERM_WAIT,
        EXTRACT,
        SQ_DOWN,
        FIN
    } fsm_t;

    // XOR one byte into the top byte (byte 47) of a state word.
    function automatic logic [STATE_W-1:0] xor_top_byte(input logic [STATE_W-1:0] s,
                                                        input logic [7:0] b);
        logic [STATE_W-1:0] r;
        r = s;
        r[STATE_W-1 -: 8] = s[STATE_W-1 -: 8] ^ b;
        return r;
    endfunction

endpackage

// File: rtl/xoodyak_block_buf.sv
// Rate-sized message block buffer: bytes land at the write pointer, clear zeroes everything.
// Latency: a written byte is visible on data the cycle after wr_en.
// Backpressure: writes while full are dropped; the caller gates wr_en with full.
module xoodyak_block_buf #(
    parameter int RATE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [7:0]              wr_data,
    output logic [8*RATE_BYTES-1:0] data,
    output logic [5:0]              wr_ptr,
    output logic                    full,
    output logic                    empty
);

    // Byte storage and write pointer; clear wins over a same-cycle write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data   <= '0;
            wr_ptr <= '0;
        end else if (clear) begin
            data   <= '0;
            wr_ptr <= '0;
        end else if (wr_en && !full) begin
            for (int k = 0; k < RATE_BYTES; k++) begin
                if (wr_ptr == 6'(k)) begin
                    data[8*k +: 8] <= wr_data;
                end
            end
            wr_ptr <= wr_ptr + 6'd1;
        end
    end

    assign full  = (wr_ptr == 6'(RATE_BYTES));
    assign empty = (wr_ptr == 6'd0);

endmodule

// File: rtl/xoodyak_hash_core.sv
// Xoodyak hash/XOF controller: absorbs a byte stream, squeezes DIGEST_BYTES via an external Xoodoo.
// Latency: per block RATE_BYTES fill + 1 down + 1 request + Lp; squeeze 1 byte/cycle per rate block.
// Backpressure: in_ready drops while a block is processed; out_valid/out_data hold until out_ready.
module xoodyak_hash_core
    import xoodyak_pkg::*;
#(
    parameter int RATE_BYTES   = 16,
    parameter int DIGEST_BYTES = 32,
    parameter int LEN_W        = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   msg_len,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               perm_start,
    output logic [STATE_W-1:0] perm_state,
    input  logic               perm_done,
    input  logic [STATE_W-1:0] perm_result,
    output logic               busy,
    output logic               done
);

    fsm_t                    fsm;
    fsm_t                    ret_tgt;
    logic [STATE_W-1:0]      st;
    logic [LEN_W-1:0]        remaining;
    logic                    first;
    logic [5:0]              ext_cnt;
    logic [11:0]             out_cnt;

    logic [8*RATE_BYTES-1:0] blk_data;
    logic [5:0]              fill_cnt;
    logic                    blk_full;
    logic                    blk_empty;
    logic                    blk_clear;
    logic                    accept;
    logic                    fill_exit;
    logic [STATE_W-1:0]      down_st;
    logic [7:0]              ext_byte;

    assign accept    = in_valid && in_ready;
    assign blk_clear = ((fsm == IDLE) && start) || (fsm == DOWN);

    // Leave FILL on the cycle the block completes or the message runs out, not one later.
    assign fill_exit = blk_full || (remaining == '0) ||
                       (accept && ((fill_cnt == 6'(RATE_BYTES - 1)) || (remaining == LEN_W'(1))));

    xoodyak_block_buf #(
        .RATE_BYTES (RATE_BYTES)
    ) u_blk (
        .clk     (clk),
        .reset   (reset),
        .clear   (blk_clear),
        .wr_en   (accept),
        .wr_data (in_data),
        .data    (blk_data),
        .wr_ptr  (fill_cnt),
        .full    (blk_full),
        .empty   (blk_empty)
    );

    // Down step: XOR buffered bytes (unused slots are zero), pad after the data, first-block domain byte.
    always_comb begin
        down_st = st;
        if (!blk_empty) begin
            for (int k = 0; k < RATE_BYTES; k++) begin
                down_st[8*k +: 8] = down_st[8*k +: 8] ^ blk_data[8*k +: 8];
            end
        end
        for (int k = 0; k <= RATE_BYTES; k++) begin
            if (fill_cnt == 6'(k)) begin
                down_st[8*k +: 8] = down_st[8*k +: 8] ^ PAD_BYTE;
            end
        end
        if (first) begin
            down_st = xor_top_byte(down_st, CD_FIRST);
        end
    end

    // Squeeze byte select within the current rate block.
    always_comb begin
        ext_byte = 8'h00;
        for (int k = 0; k < RATE_BYTES; k++) begin
            if (ext_cnt == 6'(k)) begin
                ext_byte = st[8*k +: 8];
            end
        end
    end

    // Main controller: sequencing, state register and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm       <= IDLE;
            ret_tgt   <= IDLE;
            st        <= '0;
            remaining <= '0;
            first     <= 1'b0;
            ext_cnt   <= '0;
            out_cnt   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start) begin
                        remaining <= msg_len;
                        first     <= 1'b1;
                        st        <= '0;
                        ext_cnt   <= '0;
                        out_cnt   <= '0;
                        fsm       <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        remaining <= remaining - LEN_W'(1);
                    end
                    if (fill_exit) begin
                        fsm <= DOWN;
                    end
                end
                DOWN: begin
                    st    <= down_st;
                    first <= 1'b0;
                    if (remaining != '0) begin
                        ret_tgt <= FILL;
                        fsm     <= PERM_REQ;
                    end else begin
                        fsm <= SQ_UP;
                    end
                end
                SQ_UP: begin
                    st      <= xor_top_byte(st, CU_SQUEEZE);
                    ret_tgt <= EXTRACT;
                    fsm     <= PERM_REQ;
                end
                PERM_REQ: begin
                    fsm <= PERM_WAIT;
                end
                PERM_WAIT: begin
                    if (perm_done) begin
                        st  <= perm_result;
                        fsm <= ret_tgt;
                    end
                end
                EXTRACT: begin
                    if (out_ready) begin
                        ext_cnt <= ext_cnt + 6'd1;
                        out_cnt <= out_cnt + 12'd1;
                        if (out_cnt == 12'(DIGEST_BYTES - 1)) begin
                            fsm <= FIN;
                        end else if (ext_cnt == 6'(RATE_BYTES - 1)) begin
                            fsm <= SQ_DOWN;
                        end
                    end
                end
                SQ_DOWN: begin
                    st[7:0] <= st[7:0] ^ PAD_BYTE;
                    ext_cnt <= '0;
                    ret_tgt <= EXTRACT;
                    fsm     <= PERM_REQ;
                end
                FIN: begin
                    fsm <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode only flops, so they are glitch-free of inputs and stable while stalled.
    assign in_ready   = (fsm == FILL) && !blk_full && (remaining != '0);
    assign out_valid  = (fsm == EXTRACT);
    assign out_data   = (fsm == EXTRACT) ? ext_byte : 8'h00;
    assign out_last   = (fsm == EXTRACT) && (out_cnt == 12'(DIGEST_BYTES - 1));
    assign perm_start = (fsm == PERM_REQ);
    assign perm_state = st;
    assign busy       = (fsm != IDLE);
    assign done       = (fsm == FIN);

endmodule

// File: tb/tb_xoodyak_hash_core.sv
// Directed bench for xoodyak_hash_core with identity permutation stubs of configurable latency.
// Latency: stub answers perm_start after Lp cycles.
// Backpressure: in_valid/out_ready are driven with or without random gaps.
module tb_xoodyak_hash_core;

    localparam int RATE = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_a = 1'b0, start_b = 1'b0;
    logic [11:0]  msg_len = '0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = '0;
    logic         out_ready = 1'b0;

    logic         in_ready_a, out_valid_a, out_last_a, perm_start_a, busy_a, done_a;
    logic [7:0]   out_data_a;
    logic [383:0] perm_state_a;
    logic         perm_done_a = 1'b0;
    logic [383:0] perm_result_a = '0;

    logic         in_ready_b, out_valid_b, out_last_b, perm_start_b, busy_b, done_b;
    logic [7:0]   out_data_b;
    logic [383:0] perm_state_b;
    logic         perm_done_b = 1'b0;
    logic [383:0] perm_result_b = '0;

    always #5 clk = ~clk;

    xoodyak_hash_core u_dut_a (
        .clk (clk), .reset (reset), .start (start_a), .msg_len (msg_len),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready_a),
        .out_valid (out_valid_a), .out_data (out_data_a), .out_last (out_last_a),
        .out_ready (out_ready), .perm_start (perm_start_a), .perm_state (perm_state_a),
        .perm_done (perm_done_a), .perm_result (perm_result_a), .busy (busy_a), .done (done_a)
    );

    xoodyak_hash_core #(.RATE_BYTES (16), .DIGEST_BYTES (40), .LEN_W (12)) u_dut_b (
        .clk (clk), .reset (reset), .start (start_b), .msg_len (msg_len),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready_b),
        .out_valid (out_valid_b), .out_data (out_data_b), .out_last (out_last_b),
        .out_ready (out_ready), .perm_start (perm_start_b), .perm_state (perm_state_b),
        .perm_done (perm_done_b), .perm_result (perm_result_b), .busy (busy_b), .done (done_b)
    );

    // Identity permutation stubs with Lp = cycles from perm_start to perm_done.
    int           lp_a = 1, lp_b = 1;
    int           nst_a = 0, nst_b = 0;
    int           cnt_a = 0, cnt_b = 0;
    bit           pend_a = 1'b0, pend_b = 1'b0;
    logic [383:0] held_a = '0, held_b = '0;
    logic [383:0] rec_a [0:31];

    always @(posedge clk) begin
        perm_done_a <= 1'b0;
        if (perm_start_a) begin
            if (nst_a < 32) rec_a[nst_a] <= perm_state_a;
            nst_a  <= nst_a + 1;
            held_a <= perm_state_a;
            if (lp_a == 1) begin
                perm_done_a   <= 1'b1;
                perm_result_a <= perm_state_a;
            end else begin
                pend_a <= 1'b1;
                cnt_a  <= lp_a - 1;
            end
        end else if (pend_a) begin
            if (cnt_a == 1) begin
                perm_done_a   <= 1'b1;
                perm_result_a <= held_a;
                pend_a        <= 1'b0;
            end else begin
                cnt_a <= cnt_a - 1;
            end
        end
    end

    always @(posedge clk) begin
        perm_done_b <= 1'b0;
        if (perm_start_b) begin
            nst_b  <= nst_b + 1;
            held_b <= perm_state_b;
            if (lp_b == 1) begin
                perm_done_b   <= 1'b1;
                perm_result_b <= perm_state_b;
            end else begin
                pend_b <= 1'b1;
                cnt_b  <= lp_b - 1;
            end
        end else if (pend_b) begin
            if (cnt_b == 1) begin
                perm_done_b   <= 1'b1;
                perm_result_b <= held_b;
                pend_b        <= 1'b0;
            end else begin
                cnt_b <= cnt_b - 1;
            end
        end
    end

    // Active instance view for the transaction task.
    logic       cur = 1'b0;
    logic       iready, ovalid, olast, dn;
    logic [7:0] odata;
    assign iready = cur ? in_ready_b  : in_ready_a;
    assign ovalid = cur ? out_valid_b : out_valid_a;
    assign odata  = cur ? out_data_b  : out_data_a;
    assign olast  = cur ? out_last_b  : out_last_a;
    assign dn     = cur ? done_b      : done_a;

    int         ncmp = 0, nfail = 0;
    logic [7:0] msg  [0:127];
    logic [7:0] got  [0:63];
    logic [7:0] got2 [0:63];
    logic [7:0] expd [0:63];
    int         nout, nlast, last_pos, first_nst;
    bit         fin;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cyclist hash with an identity permutation: absorb blocks, then squeeze.
    task automatic model(input int len, input int dig);
        logic [7:0] s [0:47];
        int pos, blk;
        bit f;
        for (int k = 0; k < 48; k++) s[k] = 8'h00;
        pos = 0;
        f   = 1'b1;
        do begin
            blk = (len - pos > RATE) ? RATE : len - pos;
            for (int k = 0; k < blk; k++) s[k] = s[k] ^ msg[pos + k];
            s[blk] = s[blk] ^ 8'h01;
            if (f) s[47] = s[47] ^ 8'h03;
            f   = 1'b0;
            pos = pos + blk;
        end while (pos < len);
        s[47] = s[47] ^ 8'h40;
        for (int i = 0; i < dig; i++) begin
            if (i > 0 && (i % RATE) == 0) s[0] = s[0] ^ 8'h01;
            expd[i] = s[i % RATE];
        end
    endtask

    task automatic cmp_digest(input string tag, input int dig);
        check({tag, "_count"}, 64'(nout), 64'(dig));
        for (int i = 0; i < dig; i++) check($sformatf("%s_b%0d", tag, i), 64'(got[i]), 64'(expd[i]));
    endtask

    task automatic run_hash(input bit sel, input int len, input bit gaps, input int dig);
        int idx;
        cur     = sel;
        msg_len = 12'(len);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        idx = 0; nout = 0; nlast = 0; last_pos = -1; first_nst = -1; fin = 1'b0;
        for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
            in_valid  = (idx < len) && (!gaps || ($urandom_range(0, 2) != 0));
            in_data   = (idx < 128) ? msg[idx] : 8'h00;
            out_ready = !gaps || ($urandom_range(0, 1) != 0);
            @(negedge clk);
            if (cyc == 0 && len > 0) check("in_ready_after_start", 64'(iready), 64'd1);
            if (in_valid && iready) idx++;
            if (ovalid && out_ready) begin
                if (nout < 64) got[nout] = odata;
                if (olast) begin
                    nlast++;
                    last_pos = nout;
                end
                nout++;
                if (nout == 1) first_nst = sel ? nst_b : nst_a;
            end
            if (dn) fin = 1'b1;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("done_within_budget", 64'(fin), 64'd1);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    int base, nst_end;

    initial begin
        // Reset values.
        #1;
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_in_ready", 64'(in_ready_a), 64'd0);
        check("rst_perm_start", 64'(perm_start_a), 64'd0);
        check("rst_perm_state_or", 64'(|perm_state_a), 64'd0);
        check("rst_done_last_data", {54'd0, done_a, out_last_a, out_data_a}, 64'd0);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(1);

        // Empty message, Lp = 1.
        lp_a = 1;
        base = nst_a;
        run_hash(1'b0, 0, 1'b0, 32);
        check("empty_ps_b0", 64'(rec_a[base][7:0]), 64'h01);
        check("empty_ps_b47", 64'(rec_a[base][383:376]), 64'h43);
        check("empty_d0", 64'(got[0]), 64'h01);
        check("empty_d16", 64'(got[16]), 64'h00);
        check("empty_last_pos", 64'(last_pos), 64'd31);
        model(0, 32);
        cmp_digest("empty", 32);
        check("empty_idle_after", 64'(busy_a), 64'd0);

        // Exactly one full block, bytes 0x00..0x0F, Lp = 3.
        for (int i = 0; i < 128; i++) msg[i] = 8'(i);
        lp_a = 3;
        base = nst_a;
        run_hash(1'b0, 16, 1'b0, 32);
        check("m16_ps_b15", 64'(rec_a[base][127:120]), 64'h0F);
        check("m16_ps_b16", 64'(rec_a[base][135:128]), 64'h01);
        check("m16_ps_b47", 64'(rec_a[base][383:376]), 64'h43);
        check("m16_absorb_perms", 64'(first_nst - base), 64'd1);
        check("m16_d15", 64'(got[15]), 64'h0F);
        check("m16_d16", 64'(got[16]), 64'h01);
        check("m16_d17", 64'(got[17]), 64'h01);
        check("m16_d18", 64'(got[18]), 64'h02);
        model(16, 32);
        cmp_digest("m16", 32);

        // Block boundary plus one byte, Lp = 2.
        lp_a = 2;
        base = nst_a;
        run_hash(1'b0, 17, 1'b0, 32);
        check("m17_perms_before_squeeze", 64'(first_nst - base), 64'd2);
        check("m17_ps_b0", 64'(rec_a[base + 1][7:0]), 64'h10);
        check("m17_ps_b1", 64'(rec_a[base + 1][15:8]), 64'h00);
        check("m17_ps_b16", 64'(rec_a[base + 1][135:128]), 64'h01);
        check("m17_ps_b47", 64'(rec_a[base + 1][383:376]), 64'h43);
        model(17, 32);
        cmp_digest("m17", 32);

        // 40-byte digest, Lp = 7: gap-free reference run, then a run with random gaps.
        for (int i = 0; i < 128; i++) msg[i] = 8'(i * 37 + 5);
        lp_b = 7;
        run_hash(1'b1, 20, 1'b0, 40);
        for (int i = 0; i < 40; i++) got2[i] = got[i];
        model(20, 40);
        cmp_digest("d40_nogap", 40);
        base = nst_b;
        run_hash(1'b1, 20, 1'b1, 40);
        nst_end = nst_b;
        for (int i = 0; i < 40; i++) check($sformatf("d40_gap_vs_nogap_b%0d", i), 64'(got[i]), 64'(got2[i]));
        check("d40_count", 64'(nout), 64'd40);
        check("d40_last_count", 64'(nlast), 64'd1);
        check("d40_last_pos", 64'(last_pos), 64'd39);
        check("d40_squeeze_perms", 64'(nst_end - first_nst + 1), 64'd3);
        check("d40_total_perms", 64'(nst_end - base), 64'd4);

        // Reset while stalled in EXTRACT.
        cur = 1'b0;
        lp_a = 1;
        msg_len = 12'd0;
        start_a = 1'b1;
        wait_cycles(1);
        start_a = 1'b0;
        for (int i = 0; i < 100 && !out_valid_a; i++) wait_cycles(1);
        check("rx_reached_extract", 64'(out_valid_a), 64'd1);
        wait_cycles(3);
        check("rx_held_data", 64'(out_data_a), 64'h01);
        reset = 1'b1;
        #1;
        check("rx_out_valid", 64'(out_valid_a), 64'd0);
        check("rx_out_data", 64'(out_data_a), 64'd0);
        check("rx_busy", 64'(busy_a), 64'd0);
        check("rx_perm_state_or", 64'(|perm_state_a), 64'd0);
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(2);

        // Reset while waiting on a slow permutation; its late perm_done must be ignored.
        lp_a = 20;
        start_a = 1'b1;
        wait_cycles(1);
        start_a = 1'b0;
        for (int i = 0; i < 100 && !perm_start_a; i++) wait_cycles(1);
        check("rw_saw_perm_start", 64'(perm_start_a), 64'd1);
        wait_cycles(5);
        check("rw_busy_before", 64'(busy_a), 64'd1);
        reset = 1'b1;
        #1;
        check("rw_busy", 64'(busy_a), 64'd0);
        check("rw_perm_start", 64'(perm_start_a), 64'd0);
        check("rw_perm_state_or", 64'(|perm_state_a), 64'd0);
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(30);
        check("rw_late_done_busy", 64'(busy_a), 64'd0);
        check("rw_late_done_valid", 64'(out_valid_a), 64'd0);
        check("rw_late_done_state", 64'(|perm_state_a), 64'd0);

        // Fresh hash after the resets.
        for (int i = 0; i < 128; i++) msg[i] = 8'(i);
        lp_a = 4;
        run_hash(1'b0, 16, 1'b0, 32);
        check("post_rst_d16", 64'(got[16]), 64'h01);
        model(16, 32);
        cmp_digest("post_rst", 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/xoodyak_hash_core.md
# xoodyak_hash_core

Parametrised Xoodyak hash/XOF mode controller. Accepts a message as a byte stream with valid/ready, performs Xoodyak Cyclist absorb (Down/Up) with correct padding and domain bytes, and squeezes a digest of configurable length as a byte stream. It drives an external 384-bit Xoodoo permutation through a start/done handshake, so one permutation instance can be shared or swapped for a faster unrolled version.

## Interface
Parameters:
- RATE_BYTES, 16: absorb/squeeze rate in bytes; legal range 1..44.
- DIGEST_BYTES, 32: digest length in bytes; legal range 1..4095.
- LEN_W, 12: width of the message-length field.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to hash; sampled only in IDLE.
- msg_len  in  LEN_W  message length in bytes, sampled with start; 0 is legal.
- in_valid  in  1  message byte valid.
- in_data  in  8  message byte.
- in_ready  out  1  core accepts in_data this cycle.
- out_valid  out  1  digest byte valid; held until accepted.
- out_data  out  8  digest byte.
- out_last  out  1  marks the final digest byte.
- out_ready  in  1  sink accepts out_data.
- perm_start  out  1  one-cycle pulse; perm_state is valid with it.
- perm_state  out  384  state presented to the permutation; byte i = bits [8i+7:8i].
- perm_done  in  1  one-cycle pulse; perm_result is valid with it.
- perm_result  in  384  permuted state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final digest byte is accepted.

## Operation
- Reset: all outputs are 0, FSM is in IDLE, and the state register, counters and block buffer are cleared.
- IDLE: on start, latch remaining=msg_len, set first=1, clear the state register and buffer, then go to FILL. start is ignored in all other states.
- FILL: in_ready=1 while fill_cnt<RATE_BYTES and remaining>0. Each accepted byte is written to buf[fill_cnt]; fill_cnt increments and remaining decrements. Go to DOWN when fill_cnt==RATE_BYTES or remaining==0. An empty message passes through FILL in 1 cycle.
- DOWN (1 cycle):
  - state byte k ^= buf[k] for k<fill_cnt.
  - state byte fill_cnt ^= 0x01. A full block pads at byte RATE_BYTES.
  - state byte 47 ^= (first ? 0x03 : 0x00).
  - Clear first and fill_cnt.
  - If remaining>0, go to PERM_REQ with return target FILL. Otherwise go to SQ_UP.
- Block count is max(1, ceil(msg_len/RATE_BYTES)). A length that is a multiple of RATE_BYTES adds no extra block.
- SQ_UP (1 cycle): state byte 47 ^= 0x40, then go to PERM_REQ with return target EXTRACT.
- PERM_REQ (1 cycle): perm_start=1, perm_state=state register. Then go to PERM_WAIT.
- PERM_WAIT: on perm_done, state register <= perm_result, then go to the return target. perm_done outside PERM_WAIT is ignored.
- EXTRACT: out_valid=1 and out_data=state byte ext_cnt.
  - On each out_ready handshake, ext_cnt and out_cnt increment.
  - out_last=1 when out_cnt==DIGEST_BYTES-1.
  - After the last byte, go to FIN.
  - Otherwise, if ext_cnt reaches RATE_BYTES, go to SQ_DOWN.
- SQ_DOWN (1 cycle): state byte 0 ^= 0x01, ext_cnt=0, then go to PERM_REQ with return target EXTRACT.
- FIN (1 cycle): done=1, then go to IDLE.
- Width rules:
  - fill_cnt and ext_cnt are 6 bits.
  - out_cnt is 12 bits.
  - remaining is LEN_W bits and never underflows, because decrement happens only on handshake with remaining>0.

## Timing
- start to in_ready=1: 1 cycle.
- Per absorbed block with in_valid held high: RATE_BYTES FILL cycles, 1 DOWN cycle, 1 PERM_REQ cycle, plus Lp PERM_WAIT cycles. Lp is the cycle count from perm_start to perm_done, at least 1.
- Last block to first out_valid: 1 (DOWN) + 1 (SQ_UP) + 1 + Lp cycles.
- With out_ready held high, each squeeze block emits 1 byte per cycle. Each further block costs 1 (SQ_DOWN) + 1 + Lp cycles.
- out_valid, out_data and out_last are registered and stable under out_ready=0.
- Reset asserted mid-operation: the next edge-free instant returns all outputs to 0. An in-flight perm_done is ignored afterwards.

## Structure
- Package xoodyak_pkg holds:
  - STATE_BYTES=48 and STATE_W=384.
  - PAD_BYTE=8'h01, CD_FIRST=8'h03, CU_SQUEEZE=8'h40.
  - The FSM state enum: IDLE, FILL, DOWN, SQ_UP, PERM_REQ, PERM_WAIT, EXTRACT, SQ_DOWN, FIN.
- One sub-module, xoodyak_block_buf: a RATE_BYTES byte buffer with write pointer, clear and full/empty flags, used in FILL and DOWN.

## Test plan
The bench uses an identity permutation stub with Lp configurable 1..20, plus a real Xoodoo model.
- Empty message, identity stub, defaults -> perm_state byte0=0x01, byte47=0x43. Digest is bytes 0x01 followed by 31 × 0x00, then done pulses.
- msg_len=16, bytes 0x00..0x0F -> one absorb block, perm_state byte16=0x01, byte47=0x43. Digest first 16 = 0x00..0x0F, second 16 = 0x01,0x01,0x02..0x0F.
- msg_len=17, bytes 0x00..0x10 -> 2 perm_start pulses before squeeze. The second-block DOWN gives byte0=0x10, byte1=0x00, byte47=0x03^0x40=0x43.
- Random in_valid and out_ready gaps, Lp=7, DIGEST_BYTES=40 -> the byte sequence is identical to the no-gap run. out_last occurs on byte 39 only, with 3 squeeze permutations.
- reset raised mid-EXTRACT and mid-PERM_WAIT -> all outputs become 0 immediately. A late perm_done is ignored, and a following start hashes correctly.
- Real Xoodoo model, messages of length 0, 1, 15, 16, 17, 100 -> digests match the software Xoodyak Hash reference.
